// File: rtl/route_rr_arbiter.sv
// route_rr_arbiter: round-robin burst arbiter sharing one route channel among 8 requesters
module route_rr_arbiter #(
  parameter int N_REQ = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] valid_in,
  input  logic [N_REQ-1:0] last_in,
  input  logic             beat_ready,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       sel,
  output logic             busy,
  output logic             beat_fire,
  output logic [CNT_W-1:0] beat_cnt
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [2:0] ptr, pick;
  logic done;
  // Descending scan so the requester closest to ptr wins
  always_comb begin
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[3'(ptr + 3'(k))]) pick = 3'(ptr + 3'(k));
  end
  assign beat_fire = busy & valid_in[sel] & beat_ready;
  assign done = (beat_fire & last_in[sel]) | (~req[sel] & ~beat_fire);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      beat_cnt <= '0;
      ptr      <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        state    <= BUSY;
        sel      <= pick;
        grant    <= N_REQ'(1) << pick;
        busy     <= 1'b1;
        beat_cnt <= '0;
      end
    end else begin
      if (beat_fire && beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
      if (done) begin
        state <= IDLE;
        ptr   <= sel + 3'd1;
        grant <= '0;
        busy  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_route_rr_arbiter.sv
// tb_route_rr_arbiter: table vectors, directed corner sequences and random traffic vs a reference model
module tb_route_rr_arbiter;
  logic clk = 0, rst;
  logic [7:0] req, valid_in, last_in, grant;
  logic beat_ready, busy, beat_fire;
  logic [2:0] sel;
  logic [7:0] beat_cnt;
  int n_chk = 0, n_fail = 0;

  route_rr_arbiter #(.N_REQ(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .valid_in(valid_in), .last_in(last_in),
    .beat_ready(beat_ready), .grant(grant), .sel(sel), .busy(busy),
    .beat_fire(beat_fire), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int m_busy = 0, m_sel = 0, m_ptr = 0, m_cnt = 0;

  function automatic logic m_fire();
    return m_busy != 0 && valid_in[m_sel] && beat_ready;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_step();
    logic f;
    int found;
    f = m_fire();
    if (rst) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_busy == 0) begin
      found = 0;
      for (int k = 0; k < 8; k++)
        if (!found && req[(m_ptr + k) % 8]) begin
          found = 1; m_sel = (m_ptr + k) % 8; m_busy = 1; m_cnt = 0;
        end
    end else begin
      if (f) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      if ((f && last_in[m_sel]) || (!req[m_sel] && !f)) begin
        m_busy = 0; m_ptr = (m_sel + 1) % 8;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [7:0] rq, input logic [7:0] v,
                     input logic [7:0] l, input logic rd);
    @(negedge clk);
    rst = r; req = rq; valid_in = v; last_in = l; beat_ready = rd;
    #1 chk("beat_fire", 32'(beat_fire), 32'(m_fire()));
    @(posedge clk);
    model_step();
    #1;
    chk("grant", 32'(grant), m_busy != 0 ? 32'(1) << m_sel : 32'h0);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
  endtask

  typedef struct {
    logic r; logic [7:0] rq, v, l; logic rd;
    logic [7:0] eg; logic eb; logic [2:0] es; logic [7:0] ec;
  } vec_t;
  vec_t tbl[20];

  initial begin
    rst = 1; req = 0; valid_in = 0; last_in = 0; beat_ready = 0;
    // Reset with all requests, then 1-beat bursts rotating 0..7,0
    for (int i = 0; i < 2; i++) tbl[i] = '{1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'd0};
    for (int i = 0; i < 9; i++) begin
      tbl[2 + 2*i] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'(1 << (i % 8)), 1'b1, 3'(i % 8), 8'd0};
      tbl[3 + 2*i] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 3'(i % 8), 8'd1};
    end
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].r, tbl[i].rq, tbl[i].v, tbl[i].l, tbl[i].rd);
      chk("tbl grant", 32'(grant), 32'(tbl[i].eg));
      chk("tbl busy", 32'(busy), 32'(tbl[i].eb));
      chk("tbl sel", 32'(sel), 32'(tbl[i].es));
      chk("tbl cnt", 32'(beat_cnt), 32'(tbl[i].ec));
    end
    // Skip/wrap: serve idx 5 to set ptr=6, then req=0000_0101
    cyc(0, 8'h20, 8'h00, 8'h00, 1); chk("t3 g5", 32'(grant), 32'h20);
    cyc(0, 8'h20, 8'h20, 8'h20, 1);
    cyc(0, 8'h05, 8'h00, 8'h00, 1); chk("t3 g0", 32'(grant), 32'h01);
    cyc(0, 8'h05, 8'h01, 8'h01, 1);
    cyc(0, 8'h05, 8'h00, 8'h00, 1); chk("t3 g2", 32'(grant), 32'h04);
    cyc(0, 8'h05, 8'h04, 8'h04, 1);
    cyc(0, 8'h05, 8'h00, 8'h00, 1); chk("t3 g0b", 32'(grant), 32'h01);
    cyc(0, 8'h05, 8'h01, 8'h01, 1);
    // Burst hold on idx 3 with beat_ready 1,0,1,1,0,1
    cyc(0, 8'h08, 8'h00, 8'h00, 1); chk("t4 g3", 32'(grant), 32'h08);
    cyc(0, 8'hFF, 8'h08, 8'h00, 1); chk("t4 hold1", 32'(grant), 32'h08);
    cyc(0, 8'hFF, 8'h08, 8'h00, 0); chk("t4 hold2", 32'(beat_cnt), 32'd1);
    cyc(0, 8'hFF, 8'h08, 8'h00, 1);
    cyc(0, 8'hFF, 8'h08, 8'h00, 1); chk("t4 hold3", 32'(grant), 32'h08);
    cyc(0, 8'hFF, 8'h08, 8'h00, 0);
    cyc(0, 8'hFF, 8'h08, 8'h08, 1);
    chk("t4 cnt", 32'(beat_cnt), 32'd4); chk("t4 idle", 32'(grant), 32'h00);
    cyc(0, 8'hFF, 8'h00, 8'h00, 1); chk("t4 g4", 32'(grant), 32'h10);
    cyc(0, 8'hFF, 8'h10, 8'h10, 1);
    // Abort: idx 5 drops req after two beats
    cyc(0, 8'hFF, 8'h00, 8'h00, 1); chk("t5 g5", 32'(grant), 32'h20);
    cyc(0, 8'hFF, 8'h20, 8'h00, 1);
    cyc(0, 8'hFF, 8'h20, 8'h00, 1);
    cyc(0, 8'hDF, 8'h00, 8'h00, 1);
    chk("t5 busy", 32'(busy), 32'd0); chk("t5 cnt", 32'(beat_cnt), 32'd2);
    cyc(0, 8'hFF, 8'h00, 8'h00, 1); chk("t5 ptr6", 32'(grant), 32'h40);
    // Reset mid-burst on idx 2
    cyc(1, 8'h00, 8'h00, 8'h00, 0);
    cyc(0, 8'h04, 8'h00, 8'h00, 1); chk("t6 g2", 32'(grant), 32'h04);
    cyc(0, 8'h04, 8'h04, 8'h00, 1);
    cyc(1, 8'h04, 8'h04, 8'h00, 1); chk("t6 drop", 32'(grant), 32'h00);
    cyc(0, 8'h00, 8'h04, 8'h04, 1);
    cyc(0, 8'hFF, 8'h00, 8'h00, 1); chk("t6 ptr0", 32'(grant), 32'h01);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) == 0, 8'($urandom) | 8'($urandom), 8'($urandom),
          8'($urandom) & 8'($urandom), $urandom_range(0, 3) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
